// File: rtl/color_overlay_gen_if.sv
// Pixel write stream between the overlay generator and a frame-buffer sink.
//   o_addr  : 18-bit frame-buffer pixel address (generator -> sink)
//   o_data  : 16-bit RGB565 pixel              (generator -> sink)
//   o_valid : o_addr/o_data hold a beat         (generator -> sink)
//   i_ready : sink accepts the beat this cycle  (sink -> generator)
interface color_overlay_gen_if;
  logic [17:0] o_addr;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready;

  modport master (output o_addr, output o_data, output o_valid, input i_ready);
  modport slave  (input o_addr, input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/color_overlay_gen.sv
// Draws a 3x3 facelet color overlay (3*SQ x 3*SQ pixels) into a frame buffer
// as a stream of address/RGB565 beats, one beat per accepted transfer.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : one-cycle request; honoured only while idle
//   i_color0..i_color8  : facelet color codes, row-major, sampled at start
//   pix (master)        : o_addr/o_data/o_valid out, i_ready in
//   o_busy              : draw in progress
//   o_done              : one-cycle pulse after the final beat transfers
module color_overlay_gen #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned X0    = 0,
  parameter int unsigned Y0    = 0,
  parameter int unsigned SQ    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [2:0]                 i_color0,
  input  logic [2:0]                 i_color1,
  input  logic [2:0]                 i_color2,
  input  logic [2:0]                 i_color3,
  input  logic [2:0]                 i_color4,
  input  logic [2:0]                 i_color5,
  input  logic [2:0]                 i_color6,
  input  logic [2:0]                 i_color7,
  input  logic [2:0]                 i_color8,
  color_overlay_gen_if.master        pix,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned SQ_W      = (SQ > 1) ? $clog2(SQ) : 1;
  localparam int unsigned BASE_ADDR = Y0 * H_RES + X0;
  // Jump from the last pixel of one overlay line to the first of the next.
  localparam int unsigned LINE_STEP = H_RES - 3 * SQ + 1;
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQ - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  function automatic logic [DATA_W-1:0] rgb565(input logic [2:0] c);
    case (c)
      3'd0:    return 16'hF800;
      3'd1:    return 16'hFC00;
      3'd2:    return 16'hFFE0;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'h001F;
      3'd5:    return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  state_t            r_state, w_state_nxt;
  logic [SQ_W-1:0]   r_sx, r_sy, w_sx_nxt, w_sy_nxt, w_sx_inc, w_sy_inc;
  logic [1:0]        r_cx, r_cy, w_cx_nxt, w_cy_nxt, w_cx_inc, w_cy_inc;
  logic [8:0][2:0]   r_snap, w_snap_nxt, w_colors;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_inc;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, r_busy, r_done;
  logic              w_valid_nxt, w_busy_nxt, w_done_nxt;
  logic              w_xfer, w_x_end, w_y_end, w_last;
  logic [3:0]        w_cell_inc;

  assign w_colors = {i_color8, i_color7, i_color6, i_color5, i_color4,
                     i_color3, i_color2, i_color1, i_color0};

  assign w_xfer  = r_valid & pix.i_ready;
  assign w_x_end = (r_sx == SQ_LAST) && (r_cx == 2'd2);
  assign w_y_end = (r_sy == SQ_LAST) && (r_cy == 2'd2);
  assign w_last  = w_x_end & w_y_end;

  // Position of the beat following the one currently presented.
  always_comb begin
    w_sx_inc   = r_sx + SQ_W'(1);
    w_cx_inc   = r_cx;
    w_sy_inc   = r_sy;
    w_cy_inc   = r_cy;
    w_addr_inc = r_addr + ADDR_W'(1);
    if (r_sx == SQ_LAST) begin
      w_sx_inc = '0;
      w_cx_inc = (r_cx == 2'd2) ? 2'd0 : r_cx + 2'd1;
    end
    if (w_x_end) begin
      w_addr_inc = r_addr + ADDR_W'(LINE_STEP);
      w_sy_inc   = r_sy + SQ_W'(1);
      if (r_sy == SQ_LAST) begin
        w_sy_inc = '0;
        w_cy_inc = (r_cy == 2'd2) ? 2'd0 : r_cy + 2'd1;
      end
    end
  end

  assign w_cell_inc = 4'(w_cy_inc) * 4'd3 + 4'(w_cx_inc);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = DRAW;
      DRAW:    if (w_xfer && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; flags follow the upcoming state so they
  // leave the flops aligned with it.
  always_comb begin
    w_sx_nxt    = r_sx;
    w_cx_nxt    = r_cx;
    w_sy_nxt    = r_sy;
    w_cy_nxt    = r_cy;
    w_snap_nxt  = r_snap;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_valid_nxt = (w_state_nxt == DRAW);
    w_busy_nxt  = (w_state_nxt == DRAW);
    w_done_nxt  = (w_state_nxt == DONE);
    case (r_state)
      IDLE: begin
        if (i_start) begin
          // Snapshot is loaded this cycle, so beat 0 colors straight from the input.
          w_snap_nxt = w_colors;
          w_sx_nxt   = '0;
          w_cx_nxt   = '0;
          w_sy_nxt   = '0;
          w_cy_nxt   = '0;
          w_addr_nxt = ADDR_W'(BASE_ADDR);
          w_data_nxt = rgb565(i_color0);
        end
      end
      DRAW: begin
        if (w_xfer) begin
          w_sx_nxt   = w_sx_inc;
          w_cx_nxt   = w_cx_inc;
          w_sy_nxt   = w_sy_inc;
          w_cy_nxt   = w_cy_inc;
          w_addr_nxt = w_addr_inc;
          w_data_nxt = rgb565(r_snap[w_cell_inc]);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sx    <= '0;
      r_cx    <= '0;
      r_sy    <= '0;
      r_cy    <= '0;
      r_snap  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sx    <= w_sx_nxt;
      r_cx    <= w_cx_nxt;
      r_sy    <= w_sy_nxt;
      r_cy    <= w_cy_nxt;
      r_snap  <= w_snap_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign pix.o_addr  = r_addr;
  assign pix.o_data  = r_data;
  assign pix.o_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_color_overlay_gen.sv
// Bench for color_overlay_gen: expected beats are queued when a draw is
// started; a negedge monitor compares every presented beat against the head.
module tb_color_overlay_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start_b, ready;
  logic [2:0] col [9];
  logic       busy_a, done_a, busy_b, done_b;

  color_overlay_gen_if pa();
  color_overlay_gen_if pb();
  assign pa.i_ready = ready;
  assign pb.i_ready = 1'b1;

  color_overlay_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_color0(col[0]), .i_color1(col[1]), .i_color2(col[2]),
    .i_color3(col[3]), .i_color4(col[4]), .i_color5(col[5]),
    .i_color6(col[6]), .i_color7(col[7]), .i_color8(col[8]),
    .pix(pa), .o_busy(busy_a), .o_done(done_a)
  );

  color_overlay_gen #(.X0(100), .Y0(50)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .i_color0(col[0]), .i_color1(col[1]), .i_color2(col[2]),
    .i_color3(col[3]), .i_color4(col[4]), .i_color5(col[5]),
    .i_color6(col[6]), .i_color7(col[7]), .i_color8(col[8]),
    .pix(pb), .o_busy(busy_b), .o_done(done_b)
  );

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          done_cnt = 0, beats_a = 0, beats_b = 0;
  int          valid_run = 0, last_run = 0;
  bit          prev_final = 1'b0;
  logic [17:0] acc_addr [2304];
  logic [15:0] acc_data [2304];
  logic [17:0] b_addr   [2304];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_rgb(input logic [2:0] c);
    case (c)
      3'd0:    return 16'hF800;
      3'd1:    return 16'hFC00;
      3'd2:    return 16'hFFE0;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'h001F;
      3'd5:    return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Full expected frame for dut_a (default geometry) using the current colors.
  task automatic push_frame();
    for (int y = 0; y < 48; y++) begin
      for (int x = 0; x < 48; x++) begin
        beat_t b;
        b.addr = 18'(y * 320 + x);
        b.data = exp_rgb(col[(y / 16) * 3 + x / 16]);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_beat_latency", 32'(pa.o_valid), 32'd1);
  endtask

  task automatic run_until_done(input int budget, input bit rand_ready);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    ready = 1'b1;
    chk("done_within_budget", 32'(ok), 32'd1);
    chk("done_single_cycle", 32'(done_a), 32'd0);
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (done_a) begin
      done_cnt++;
      chk("done_after_last_beat", 32'(prev_final), 32'd1);
      chk("done_busy_low", 32'(busy_a), 32'd0);
    end
    prev_final = 1'b0;
    if (pa.o_valid) begin
      valid_run++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: addr 0x%0h presented, scoreboard empty", pa.o_addr);
      end else begin
        chk("beat_addr", 32'(pa.o_addr), 32'(exp_q[0].addr));
        chk("beat_data", 32'(pa.o_data), 32'(exp_q[0].data));
        chk("beat_busy", 32'(busy_a), 32'd1);
        if (ready) begin
          if (beats_a < 2304) begin
            acc_addr[beats_a] = pa.o_addr;
            acc_data[beats_a] = pa.o_data;
          end
          beats_a++;
          void'(exp_q.pop_front());
          prev_final = (exp_q.size() == 0);
        end
      end
    end else if (valid_run != 0) begin
      last_run  = valid_run;
      valid_run = 0;
    end
  end

  // Monitor for dut_b (sink always ready, so every valid cycle is a beat).
  always @(negedge clk) begin
    if (pb.o_valid) begin
      if (beats_b < 2304) b_addr[beats_b] = pb.o_addr;
      beats_b++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    bit  ok;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; ready = 1'b1;
    col = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(pa.o_valid), 32'd0);
    chk("reset_busy",  32'(busy_a),     32'd0);
    chk("reset_done",  32'(done_a),     32'd0);
    chk("reset_addr",  32'(pa.o_addr),  32'd0);
    chk("reset_data",  32'(pa.o_data),  32'd0);
    rst = 1'b0;

    // Idle for 20 cycles: everything quiet.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_quiet", 32'({pa.o_valid, busy_a, done_a}), 32'd0);
    end

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start_valid", 32'(pa.o_valid), 32'd0);
    chk("rst_over_start_busy",  32'(busy_a),     32'd0);
    @(posedge clk); #1;
    chk("rst_over_start_later", 32'(pa.o_valid), 32'd0);

    // Full draw, sink always ready.
    beats_a = 0;
    push_frame();
    pulse_start();
    run_until_done(3000, 1'b0);
    chk("beat0_addr",    32'(acc_addr[0]),    32'd0);
    chk("beat0_data",    32'(acc_data[0]),    32'hF800);
    chk("beat16_addr",   32'(acc_addr[16]),   32'd16);
    chk("beat16_data",   32'(acc_data[16]),   32'hFC00);
    chk("beat2303_addr", 32'(acc_addr[2303]), 32'd15087);
    chk("beat2303_data", 32'(acc_data[2303]), 32'h0000);
    chk("beat_total",    32'(beats_a),        32'd2304);
    chk("valid_run_len", 32'(last_run),       32'd2304);
    chk("queue_drained", 32'(exp_q.size()),   32'd0);

    // Same draw with a randomly stalling sink.
    repeat (3) @(posedge clk);
    #1;
    beats_a = 0;
    push_frame();
    pulse_start();
    run_until_done(20000, 1'b1);
    chk("stall_beat_total", 32'(beats_a),      32'd2304);
    chk("stall_drained",    32'(exp_q.size()), 32'd0);

    // Restart attempt and color change mid-draw are ignored.
    repeat (3) @(posedge clk);
    #1;
    beats_a = 0;
    d0 = done_cnt;
    push_frame();
    pulse_start();
    repeat (500) @(posedge clk);
    #1;
    start = 1'b1;
    foreach (col[i]) col[i] = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done(3000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("midstart_one_done", 32'(done_cnt),     32'(d0 + 1));
    chk("midstart_beats",    32'(beats_a),      32'd2304);
    chk("midstart_drained",  32'(exp_q.size()), 32'd0);
    chk("midstart_idle",     32'(pa.o_valid),   32'd0);
    col = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

    // Reset in the middle of a draw abandons it.
    beats_a = 0;
    push_frame();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (beats_a >= 1000) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reached_beat_1000", 32'(ok), 32'd1);
    rst = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", 32'(pa.o_valid), 32'd0);
    chk("abort_busy",  32'(busy_a),     32'd0);
    rst = 1'b0; ready = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done",  32'(done_cnt),  32'(d0));
    chk("abort_no_beats", 32'(pa.o_valid), 32'd0);
    beats_a = 0;
    push_frame();
    pulse_start();
    chk("restart_addr", 32'(pa.o_addr), 32'd0);
    run_until_done(3000, 1'b0);
    chk("restart_beats", 32'(beats_a), 32'd2304);

    // Offset overlay on the second instance.
    beats_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("offset_done_seen", 32'(ok), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("offset_first_addr", 32'(b_addr[0]),    32'd16100);
    chk("offset_beat48",     32'(b_addr[48]),   32'd16420);
    chk("offset_last_addr",  32'(b_addr[2303]), 32'd31187);
    chk("offset_beats",      32'(beats_b),      32'd2304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_overlay_gen.md
COLOR_OVERLAY_GEN -- requirements
Module: color_overlay_gen

Interface
REQ-001 Parameter H_RES, default 320, frame-buffer line pitch in pixels.
REQ-002 Parameter X0, default 0, overlay left edge (pixels).
REQ-003 Parameter Y0, default 0, overlay top edge (lines).
REQ-004 Parameter SQ, default 16, facelet square side (pixels); overlay is 3*SQ x 3*SQ.
REQ-005 Ports (name, direction, width, meaning):
- i_clk  in  1  sole clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  single-cycle request to latch colors and draw one overlay.
- i_color0..i_color8  in  3 each  facelet color codes, row-major, 0 = top-left.
- o_addr  out  18  frame-buffer pixel address.
- o_data  out  16  RGB565 pixel.
- o_valid  out  1  o_addr/o_data hold a beat.
- i_ready  in  1  sink accepts the beat this cycle.
- o_busy  out  1  overlay draw in progress.
- o_done  out  1  single-cycle pulse, draw complete.

Function
REQ-006 FSM states IDLE, DRAW, DONE; reset state IDLE.
REQ-007 IDLE: o_valid=0, o_busy=0; on i_start=1, latch i_color0..8 into a snapshot, clear counters x=0, y=0, enter DRAW.
REQ-008 i_start is honoured in IDLE only; ignored in DRAW and DONE.
REQ-009 Color inputs are sampled only at start; changes during DRAW have no effect.
REQ-010 DRAW: o_busy=1, o_valid=1; first beat valid the cycle after i_start is sampled.
REQ-011 Beat transfers when o_valid=1 and i_ready=1; while o_valid=1 and i_ready=0, o_addr and o_data hold unchanged.
REQ-012 Scan order: x 0..3*SQ-1 within a line, then y increments; x wraps to 0 on the transfer at x=3*SQ-1.
REQ-013 o_addr = (Y0+y)*H_RES + X0 + x, 18-bit unsigned; parameters satisfy (Y0+3*SQ)*H_RES <= 2^18 (no wrap handling).
REQ-014 Cell index = (y/SQ)*3 + (x/SQ), produced by SQ-modulo sub-counters plus cell row/column counters (no divider).
REQ-015 o_data = RGB565 of snapshot[cell]: 0 red 16'hF800, 1 orange 16'hFC00, 2 yellow 16'hFFE0, 3 green 16'h07E0, 4 blue 16'h001F, 5 white 16'hFFFF, 6 and 7 (no match) black 16'h0000.
REQ-016 o_addr, o_data, o_valid are registered outputs.
REQ-017 Transfer at x=3*SQ-1, y=3*SQ-1 ends the draw: next cycle state DONE, o_valid=0.
REQ-018 DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE.
REQ-019 With i_ready held 1, o_valid is high for exactly 9*SQ*SQ consecutive cycles.

Reset
REQ-020 i_rst=1 at a clock edge forces IDLE, o_valid=0, o_busy=0, o_done=0, o_addr=0, o_data=0, counters and snapshot 0.
REQ-021 Reset during DRAW abandons the draw: no o_done, no further beats; next i_start restarts at x=0, y=0.
REQ-022 i_rst takes priority over i_start in the same cycle.

Verification
REQ-023 Reset, idle 20 cycles -> o_valid=0, o_busy=0, o_done=0 throughout.
REQ-024 Defaults, colors {0,1,2,3,4,5,5,6,7}, i_ready=1, pulse i_start -> beat 0 addr 0 data F800; beat 16 addr 16 data FC00; beat 2303 addr 15087 data 0000; 2304 beats total; o_done one cycle after last beat.
REQ-025 Same stimulus, i_ready randomly toggled -> addr/data stable across every stall; accepted beat sequence identical to REQ-024.
REQ-026 i_start re-pulsed and all colors changed to 4 mid-draw -> no restart; remaining beats use original snapshot; exactly one o_done.
REQ-027 i_rst asserted after beat 1000 -> next cycle o_valid=0, o_busy=0, no o_done; new i_start first beat addr 0.
REQ-028 X0=100, Y0=50 -> first beat addr 16100; beat 48 addr 16420; last beat addr 31187.
